// File: rtl/repetition_encoder_tx.sv
// repetition_encoder_tx: serial repetition-code transmitter with one-word hold buffer
module repetition_encoder_tx #(
  parameter int DATA_W = 8,
  parameter int REPS   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy
);
  localparam int BW = $clog2(DATA_W);
  localparam int RW = $clog2(REPS);
  if (REPS < 3 || REPS % 2 == 0) begin : g_bad_reps
    $error("REPS must be odd and >= 3");
  end
  if (DATA_W < 2) begin : g_bad_width
    $error("DATA_W must be >= 2");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] hold;
  logic [BW-1:0]     bit_idx;
  logic [RW-1:0]     rep_cnt;
  logic              hold_full;
  logic              send;
  logic              last;
  logic              consume;
  logic              accept;
  logic              done;
  assign send      = state == SEND;
  assign last      = send && bit_idx == BW'(DATA_W - 1) && rep_cnt == RW'(REPS - 1);
  assign consume   = send && out_ready;
  assign accept    = in_valid && !hold_full;
  assign done      = consume && last;
  assign in_ready  = !hold_full;
  assign out_valid = send;
  assign out_bit   = send && sh[0];
  assign out_sof   = send && bit_idx == '0 && rep_cnt == '0;
  assign out_eof   = last;
  assign busy      = send || hold_full;
  // Advance the symbol counters, then decide where an incoming or held word goes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= '0;
      hold      <= '0;
      bit_idx   <= '0;
      rep_cnt   <= '0;
      hold_full <= 1'b0;
    end else begin
      if (consume) begin
        if (rep_cnt != RW'(REPS - 1)) rep_cnt <= rep_cnt + 1'b1;
        else begin
          rep_cnt <= '0;
          sh      <= sh >> 1;
          bit_idx <= last ? '0 : bit_idx + 1'b1;
        end
      end
      if (done && hold_full) begin
        sh        <= hold;
        hold_full <= 1'b0;
      end else if (accept && (!send || done)) begin
        sh      <= in_data;
        bit_idx <= '0;
        rep_cnt <= '0;
        state   <= SEND;
      end else if (accept) begin
        hold      <= in_data;
        hold_full <= 1'b1;
      end else if (done) state <= IDLE;
    end
  end
endmodule

// File: doc/repetition_encoder_tx.md
# repetition_encoder_tx

Serial repetition-code transmitter. It accepts parallel data words over a valid/ready handshake and emits each bit LSB-first as REPS identical consecutive symbols, with start/end-of-word markers. This is the transmit end of the repetition link whose receive side is the team's majority-vote decoder. A one-word holding buffer allows back-to-back words with no idle symbol between them.

## Interface
- DATA_W, 8, data word width in bits; must be ≥ 2.
- REPS, 5, copies per bit; must be odd and ≥ 3, and elaboration fails otherwise.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is offered.
- in_ready  output  1  block can accept a word; equals !hold_full.
- in_data  input  DATA_W  word to encode.
- out_valid  output  1  out_bit/out_sof/out_eof are valid.
- out_ready  input  1  sink consumes the current symbol.
- out_bit  output  1  current encoded symbol.
- out_sof  output  1  high on the first copy of bit 0 of a word.
- out_eof  output  1  high on the last copy of bit DATA_W-1 of a word.
- busy  output  1  high when the shifter or hold buffer is occupied.

## Operation
- Storage consists of a shift register (DATA_W), bit_idx (clog2(DATA_W)), rep_cnt (clog2(REPS)), a hold register (DATA_W) and hold_full.
- States:
  - IDLE: shifter empty, out_valid = 0.
  - SEND: shifter holds a word, out_valid = 1.
- Input accept occurs when in_valid && in_ready at a clock edge.
  - If the block is in IDLE, or the last symbol of the current word is consumed at the same edge, and hold is empty: the word loads directly into the shifter. bit_idx and rep_cnt clear, and the state becomes SEND.
  - Otherwise the word goes to hold and hold_full is set.
- Symbol consume occurs when out_valid && out_ready.
  - If rep_cnt < REPS-1: rep_cnt increments.
  - Otherwise rep_cnt clears, the shifter shifts right, and bit_idx increments.
  - On the last symbol (bit_idx = DATA_W-1, rep_cnt = REPS-1):
    - if hold_full: hold moves into the shifter, hold_full clears, and the block stays in SEND;
    - else if an accept occurs at the same edge: in_data moves into the shifter;
    - else: the state goes to IDLE.
- Output values:
  - out_bit = shifter[0].
  - out_sof = (bit_idx = 0 && rep_cnt = 0 && SEND).
  - out_eof = (bit_idx = DATA_W-1 && rep_cnt = REPS-1 && SEND).
- Stability: while out_valid && !out_ready, out_bit, out_sof and out_eof hold stable. out_valid never drops mid-word.
- busy = SEND || hold_full.
- Reset is asynchronous at any time, including mid-word: the state goes to IDLE, counters and hold_full clear, and the partial word is discarded with no out_eof emitted.
- Reset values: in_ready = 1, out_valid = 0, out_bit = 0, out_sof = 0, out_eof = 0, busy = 0.

## Timing
- Latency: a word accepted in IDLE at edge N presents its first symbol (out_sof = 1) from edge N onward, i.e. in cycle N+1. There is no combinational path from in_valid to any output.
- Throughput: one symbol per cycle while out_ready = 1.
  - One word occupies DATA_W×REPS consumed symbols (40 at defaults).
  - Consecutive words show no gap: out_eof of word k is immediately followed by out_sof of word k+1 in the next cycle.
- in_ready depends only on registered state (hold_full); it has no combinational path from out_ready.
- Capacity: at most 2 words in flight (shifter + hold). A third in_valid stalls until the shifter finishes and hold drains.
- Simultaneous events:
  - accept into hold and the last-symbol consume at the same edge while hold was empty: the new word goes directly to the shifter and hold stays empty;
  - accept while hold is full: impossible, since in_ready = 0.

## Test plan
- Reset then single word: in_data = 0xA5 with out_ready = 1.
  - Expect 40 consecutive valid symbols: 1×5, 0×5, 1×5, 0×5, 0×5, 1×5, 0×5, 1×5.
  - out_sof on symbol 1, out_eof on symbol 40.
  - out_valid = 0 and busy = 0 in the cycle after.
- Backpressure: word 0x3C with out_ready toggled pseudo-randomly.
  - The sequence of consumed symbols is identical to the out_ready = 1 run.
  - Outputs hold stable during every stall cycle.
- Back-to-back: words 0x01, 0xFF, 0x80 offered continuously with out_ready = 1.
  - 0x01 goes to the shifter and 0xFF to hold.
  - in_ready stays 0 until 0x01's out_eof edge; 0x80 is then accepted into hold.
  - 120 contiguous valid symbols with exactly 3 out_sof and 3 out_eof.
- Same-edge handoff: hold empty; in_valid rises on the exact cycle of the out_eof consume.
  - The next out_sof appears in the following cycle, with no idle gap.
- Reset mid-word: assert rst_n = 0 after 17 symbols of 0xA5.
  - Outputs go immediately to reset values and no out_eof is emitted.
  - A new word 0x5A after reset encodes correctly from out_sof.
- Round-trip: random words through the block and a reference majority voter, forcing up to (REPS-1)/2 = 2 flipped symbols per 5-symbol group.
  - Every decoded word equals its input word, over 1000 words.
